// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, queue entry type and
// redirect arithmetic for the ifetch_queue front end.
package ifetch_pkg;

  localparam int INSTR_STEP = 4;
  localparam int XLEN       = 32;
  localparam int TW         = 64;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } q_entry_t;

  // Computed wide; callers truncate to AW, which is the mod 2^AW wrap.
  function automatic logic [TW-1:0] rel_target(
    input logic [TW-1:0] base,
    input logic [15:0]   immed
  );
    logic [TW-1:0] off;
    off = {{(TW-16){immed[15]}}, immed} << 2;
    return base + TW'(INSTR_STEP) + off;
  endfunction

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with count/full/empty, flush,
// and push+pop in the same cycle at any occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Flush,
  input  logic                   Push,
  input  logic [WIDTH-1:0]       Push_Data,
  input  logic                   Pop,
  output logic [WIDTH-1:0]       Pop_Data,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Full,
  output logic                   Empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign Empty    = (Count == '0);
  assign Full     = (Count == FULL_CNT);
  assign do_pop   = Pop && !Empty;
  assign do_push  = Push && (!Full || Pop);
  assign Pop_Data = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      Count <= Count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push && !Reset && !Flush)
      mem[wr_ptr] <= Push_Data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: PC, in-order pipelined imem requests, decode queue.
// Define IFETCH_PERF_EN to add Perf_Fetched/Perf_Dropped counters.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter int            QDEPTH   = 4,
  parameter int            MAX_OUT  = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Redirect_Valid,
  input  logic          Redirect_Rel,
  input  logic [AW-1:0] Redirect_Base,
  input  logic [15:0]   Redirect_Immed,
  output logic          IMem_Req,
  output logic [AW-1:0] IMem_Addr,
  input  logic          IMem_Gnt,
  input  logic          IMem_Rvalid,
  input  logic [IW-1:0] IMem_Rdata,
  output logic          Instr_Valid,
  input  logic          Instr_Ready,
  output logic [IW-1:0] Instr,
  output logic [AW-1:0] Instr_PC
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   Perf_Fetched,
  output logic [31:0]   Perf_Dropped
`endif
);

  localparam int QCW = $clog2(QDEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUT) + 1;

  logic [AW-1:0]  pc;
  logic [AW-1:0]  pc_head;
  logic [AW-1:0]  target;
  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] drop;
  logic [QCW-1:0] q_count;
  logic           pc_full, pc_empty;
  logic           q_full, q_empty;
  logic           rv, fire, pop;
  logic           dropping, push;
  logic           credit_ok;
  q_entry_t       q_in, q_out;

  assign rv       = IMem_Rvalid && !pc_empty;
  assign fire     = IMem_Req && IMem_Gnt;
  assign pop      = Instr_Valid && Instr_Ready;
  assign dropping = rv && (drop != '0);
  assign push     = rv && !dropping && !Redirect_Valid;

  assign credit_ok =
    (32'(q_count) + 32'(outstanding)) < 32'(QDEPTH);

  assign IMem_Req = !Reset && !Redirect_Valid && !q_full
                 && credit_ok && !pc_full;
  assign IMem_Addr = pc;

  assign target = Redirect_Rel
    ? AW'(rel_target(TW'(Redirect_Base), Redirect_Immed))
    : Redirect_Base;

  assign q_in = '{instr: IMem_Rdata, pc: pc_head};

  assign Instr_Valid = !q_empty;
  assign Instr       = q_empty ? '0 : IW'(q_out.instr);
  assign Instr_PC    = q_empty ? '0 : AW'(q_out.pc);

  sync_fifo #(.WIDTH(AW), .DEPTH(MAX_OUT)) u_pc_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (1'b0),
    .Push      (fire),
    .Push_Data (pc),
    .Pop       (rv),
    .Pop_Data  (pc_head),
    .Count     (outstanding),
    .Full      (pc_full),
    .Empty     (pc_empty)
  );

  sync_fifo #(.WIDTH($bits(q_entry_t)), .DEPTH(QDEPTH)) u_iq (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Redirect_Valid),
    .Push      (push),
    .Push_Data (q_in),
    .Pop       (pop),
    .Pop_Data  (q_out),
    .Count     (q_count),
    .Full      (q_full),
    .Empty     (q_empty)
  );

  // After a redirect every response still in flight is stale.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else if (Redirect_Valid) begin
      pc   <= target;
      drop <= outstanding - OCW'(rv);
    end else begin
      if (fire)     pc   <= pc + AW'(INSTR_STEP);
      if (dropping) drop <= drop - OCW'(1);
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] n_disc;

  assign n_disc = 32'(rv && (dropping || Redirect_Valid))
    + (Redirect_Valid ? 32'(q_count) - 32'(pop) : 32'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Perf_Fetched <= '0;
      Perf_Dropped <= '0;
    end else begin
      Perf_Fetched <= sat_add32(Perf_Fetched, 32'(pop));
      Perf_Dropped <= sat_add32(Perf_Dropped, n_disc);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: vector table, directed corner sequences and
// random traffic against an epoch-tagged scoreboard.
module tb_ifetch_queue;

  localparam int          QD  = 4;
  localparam int          MO  = 4;
  localparam logic [31:0] RPC = 32'h100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Redirect_Valid = 1'b0;
  logic        Redirect_Rel = 1'b0;
  logic [31:0] Redirect_Base = '0;
  logic [15:0] Redirect_Immed = '0;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Gnt = 1'b0;
  logic        IMem_Rvalid = 1'b0;
  logic [31:0] IMem_Rdata = '0;
  logic        Instr_Valid;
  logic        Instr_Ready = 1'b0;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
`ifdef IFETCH_PERF_EN
  logic [31:0] Perf_Fetched;
  logic [31:0] Perf_Dropped;
`endif

  ifetch_queue #(
    .AW(32), .IW(32), .QDEPTH(QD), .MAX_OUT(MO), .RESET_PC(RPC)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_Rel   (Redirect_Rel),
    .Redirect_Base  (Redirect_Base),
    .Redirect_Immed (Redirect_Immed),
    .IMem_Req       (IMem_Req),
    .IMem_Addr      (IMem_Addr),
    .IMem_Gnt       (IMem_Gnt),
    .IMem_Rvalid    (IMem_Rvalid),
    .IMem_Rdata     (IMem_Rdata),
    .Instr_Valid    (Instr_Valid),
    .Instr_Ready    (Instr_Ready),
    .Instr          (Instr),
    .Instr_PC       (Instr_PC)
`ifdef IFETCH_PERF_EN
    ,
    .Perf_Fetched   (Perf_Fetched),
    .Perf_Dropped   (Perf_Dropped)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    bit          gnt, rv, rdy;
    bit          req;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
  } vec_t;

  mreq_t memq[$];
  ent_t  mq[$];
  int    cyc = 0;
  int    epoch = 0;
  int    lat_min = 1, lat_max = 1;
  int    nfire = 0;
  int    checks = 0, errors = 0;
  int    mfet = 0, mdrop = 0;
  logic [31:0] npc = RPC;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;
  bit          arm = 0, got = 0;
  logic [31:0] got_pc = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] tgt(
    input bit rel, input logic [31:0] base, input logic [15:0] imm
  );
    int off;
    off = int'($signed(imm));
    return rel ? base + 32'd4 + 32'(off * 4) : base;
  endfunction

  task automatic check(
    input string name, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic step(
    input bit rst, input bit rd, input bit rel,
    input logic [31:0] base, input logic [15:0] imm,
    input bit gnt, input bit rva, input bit rdy
  );
    bit    rv, exp_req, fire;
    mreq_t r;
    ent_t  e;
    @(negedge Clk);
    Reset = rst;
    Redirect_Valid = rd;
    Redirect_Rel = rel;
    Redirect_Base = base;
    Redirect_Immed = imm;
    IMem_Gnt = gnt;
    Instr_Ready = rdy;
    rv = rva && (memq.size() > 0) && (memq[0].due <= cyc);
    assert (!(rv && memq.size() == 0));
    IMem_Rvalid = rv;
    IMem_Rdata = rv ? memf(memq[0].addr) : $urandom;
    #1;
    s_req = IMem_Req;
    s_addr = IMem_Addr;
    s_valid = Instr_Valid;
    s_pc = Instr_PC;
    exp_req = !rst && !rd && (mq.size() + memq.size() < QD)
              && (memq.size() < MO);
    check("req", IMem_Req, exp_req);
    if (exp_req) check("addr", IMem_Addr, npc);
    if (!rst) begin
      check("valid", Instr_Valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("instr", Instr, mq[0].instr);
        check("instr_pc", Instr_PC, mq[0].pc);
      end
`ifdef IFETCH_PERF_EN
      check("perf_fetched", Perf_Fetched, mfet);
      check("perf_dropped", Perf_Dropped, mdrop);
`endif
    end
    if (arm && !rst && Instr_Valid && rdy) begin
      got = 1;
      got_pc = Instr_PC;
      arm = 0;
    end
    if (rst) begin
      memq.delete();
      mq.delete();
      npc = RPC;
      epoch++;
      mfet = 0;
      mdrop = 0;
    end else begin
      fire = IMem_Req && gnt;
      if (fire) begin
        nfire++;
        memq.push_back('{IMem_Addr, epoch,
                         cyc + $urandom_range(lat_min, lat_max)});
      end
      if (mq.size() > 0 && rdy) begin
        void'(mq.pop_front());
        mfet++;
      end
      if (rv) begin
        r = memq.pop_front();
        if (!rd && r.epoch == epoch) begin
          e.instr = memf(r.addr);
          e.pc = r.addr;
          mq.push_back(e);
        end else begin
          mdrop++;
        end
      end
      if (rd) begin
        mdrop += mq.size();
        mq.delete();
        epoch++;
        npc = tgt(rel, base, imm);
      end else if (fire) begin
        npc = npc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, '0, 0, 0, 0);
    step(1, 0, 0, '0, '0, 0, 0, 0);
    @(posedge Clk);
    #1;
    check("rst_valid", Instr_Valid, 0);
    check("rst_instr", Instr, 0);
    check("rst_instr_pc", Instr_PC, 0);
    check("rst_req", IMem_Req, 0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 0, 1, 1, 32'h100, 0, 32'h0};
    tbl[1] = '{1, 1, 1, 1, 32'h104, 0, 32'h0};
    tbl[2] = '{1, 1, 1, 1, 32'h108, 1, 32'h100};
    tbl[3] = '{1, 1, 1, 1, 32'h10C, 1, 32'h104};
    tbl[4] = '{1, 1, 1, 1, 32'h110, 1, 32'h108};
    tbl[5] = '{1, 1, 1, 1, 32'h114, 1, 32'h10C};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, '0, '0, tbl[i].gnt, tbl[i].rv, tbl[i].rdy);
      check("tbl_req", s_req, tbl[i].req);
      check("tbl_addr", s_addr, tbl[i].addr);
      check("tbl_valid", s_valid, tbl[i].v);
      if (tbl[i].v) check("tbl_pc", s_pc, tbl[i].pc);
    end

    // Decode stalled: queue fills on credit, then resumes.
    do_reset();
    nfire = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, '0, 1, 1, 0);
    check("fill_reqs", nfire, 4);
    check("fill_stall", s_req, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, '0, '0, 1, 1, 1);

    // Relative redirect with three requests in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 1, 0, 0);
    step(0, 1, 1, 32'h200, 16'hFFFE, 1, 0, 0);
    step(0, 0, 0, '0, '0, 1, 0, 0);
    check("rel_req", s_req, 1);
    check("rel_addr", s_addr, 32'h1FC);
    arm = 1;
    got = 0;
    for (int i = 0; i < 30; i++) step(0, 0, 0, '0, '0, 1, 1, 1);
    check("rel_seen", got, 1);
    check("rel_first_pc", got_pc, 32'h1FC);

    // Absolute redirect colliding with a response and a pop.
    do_reset();
    step(0, 0, 0, '0, '0, 1, 0, 0);
    step(0, 0, 0, '0, '0, 1, 1, 0);
    step(0, 0, 0, '0, '0, 1, 0, 0);
    step(0, 1, 0, 32'h40, '0, 0, 1, 1);
    check("abs_pop_valid", s_valid, 1);
    check("abs_pop_pc", s_pc, 32'h100);
    step(0, 0, 0, '0, '0, 1, 0, 1);
    check("abs_req", s_req, 1);
    check("abs_addr", s_addr, 32'h40);
    check("abs_flushed", s_valid, 0);
    arm = 1;
    got = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, '0, 1, 1, 1);
    check("abs_seen", got, 1);
    check("abs_first_pc", got_pc, 32'h40);

    // PC wrap, then reset in the middle of traffic.
    step(0, 1, 0, 32'hFFFF_FFFC, '0, 1, 1, 1);
    step(0, 0, 0, '0, '0, 1, 1, 1);
    check("wrap_req", s_req, 1);
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, '0, '0, 1, 1, 0);
    check("wrap_addr1", s_addr, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 1, 1, 0);
    do_reset();
    step(0, 0, 0, '0, '0, 1, 0, 0);
    check("mid_rst_valid", s_valid, 0);
    check("mid_rst_addr", s_addr, RPC);

    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 24) == 0,
           1'($urandom_range(0, 1)),
           $urandom, 16'($urandom),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
